// File: rtl/quad_pkg.sv
// Shared types and phase lookup tables for the quadrature decoder.
package quad_pkg;

  typedef enum logic [2:0] {
    Q_INIT,
    Q_00,
    Q_01,
    Q_11,
    Q_10
  } quad_state_t;

  // Next-phase tables, two bits per entry, indexed by the current {a,b} phase.
  localparam logic [7:0] CW_NEXT_LUT  = {2'b10, 2'b00, 2'b11, 2'b01};
  localparam logic [7:0] CCW_NEXT_LUT = {2'b01, 2'b11, 2'b00, 2'b10};

  function automatic logic [1:0] cw_next(input logic [1:0] p);
    return CW_NEXT_LUT[{p, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] p);
    return CCW_NEXT_LUT[{p, 1'b0} +: 2];
  endfunction

  function automatic quad_state_t phase_to_state(input logic [1:0] p);
    quad_state_t s;
    case (p)
      2'b00:   s = Q_00;
      2'b01:   s = Q_01;
      2'b11:   s = Q_11;
      default: s = Q_10;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] state_phase(input quad_state_t s);
    logic [1:0] p;
    case (s)
      Q_01:    p = 2'b01;
      Q_11:    p = 2'b11;
      Q_10:    p = 2'b10;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/quadrature_decoder_debouncer.sv
// Two-flop synchronizer plus stability filter for a W-bit group of raw inputs.
module pair_debouncer #(
  parameter int unsigned W      = 2,
  parameter int unsigned CYCLES = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_filtered,
  output logic         o_changed
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [W-1:0]  r_s1, r_s2, r_cand, r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_primed, r_changed;

  logic          w_pending, w_restart, w_accept;
  logic [CW-1:0] w_cnt_next;

  // Before the first acceptance the synced value is qualified even if it
  // equals the reset value, so the decoder always gets an initial phase.
  assign w_pending  = (r_s2 != r_filt) || !r_primed;
  assign w_restart  = (r_cnt == '0) || (r_s2 != r_cand);
  assign w_cnt_next = w_restart ? CW'(1) : r_cnt + 1'b1;
  assign w_accept   = w_pending && (w_cnt_next == CW'(CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_cand    <= '0;
      r_filt    <= '0;
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_changed <= 1'b0;
      if (!w_pending) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_filt    <= r_s2;
        r_cnt     <= '0;
        r_primed  <= 1'b1;
        r_changed <= 1'b1;
      end else begin
        r_cnt  <= w_cnt_next;
        r_cand <= r_s2;
      end
    end
  end

  assign o_filtered = r_filt;
  assign o_changed  = r_changed;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: debounced A/B phases drive a saturating position counter.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned N               = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         a_in,
  input  logic         b_in,
  output logic [N-1:0] position,
  output logic         step,
  output logic         dir,
  output logic         err
);

  logic [1:0]  w_filt, w_cur_phase;
  logic        w_changed;
  quad_state_t r_state, w_state_nxt;

  logic [N-1:0] r_position, w_pos_nxt;
  logic         r_step, r_dir, r_err;
  logic         w_step_nxt, w_dir_nxt, w_err_nxt;

  pair_debouncer #(
    .W      (2),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_raw      ({a_in, b_in}),
    .o_filtered (w_filt),
    .o_changed  (w_changed)
  );

  assign w_cur_phase = state_phase(r_state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= Q_INIT;
      r_position <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_position <= w_pos_nxt;
      r_step     <= w_step_nxt;
      r_dir      <= w_dir_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Phase tracking continues while disabled; only the count is gated by ena.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_position;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    if (w_changed) begin
      w_state_nxt = phase_to_state(w_filt);
      if (r_state != Q_INIT) begin
        if (w_filt == cw_next(w_cur_phase)) begin
          if (ena && (r_position != '1)) begin
            w_pos_nxt  = r_position + 1'b1;
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b1;
          end
        end else if (w_filt == ccw_next(w_cur_phase)) begin
          if (ena && (r_position != '0)) begin
            w_pos_nxt  = r_position - 1'b1;
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b0;
          end
        end else if (w_filt != w_cur_phase) begin
          w_err_nxt = 1'b1;
        end
      end
    end
  end

  assign position = r_position;
  assign step     = r_step;
  assign dir      = r_dir;
  assign err      = r_err;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder (N=4, DEBOUNCE_CYCLES=4).
module tb_quadrature_decoder;
  import quad_pkg::*;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic         a_in = 1'b0;
  logic         b_in = 1'b0;
  logic [N-1:0] position;
  logic         step, dir, err;

  quadrature_decoder #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .a_in     (a_in),
    .b_in     (b_in),
    .position (position),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pos;
    bit step;
    bit dir;
    bit err;
    int cyc;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  int         m_pos = 0;
  bit         m_dir = 0;
  logic [1:0] m_phase = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] tb_cw(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] tb_ccw(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Every step/err pulse must match the oldest expected event, including its edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (step || err)) begin
      if (step) n_steps++;
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, step, err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("ev_pos", position, e.pos);
        chk("ev_step", step, e.step);
        chk("ev_dir", dir, e.dir);
        chk("ev_err", err, e.err);
        chk("ev_latency", cyc, e.cyc);
      end
    end
  end

  task automatic apply(input logic [1:0] p, input int hold);
    exp_t e;
    @(posedge clk);
    #1;
    {a_in, b_in} = p;
    e.cyc = cyc + 2 + DC + 1;
    if (p != m_phase) begin
      if (p == tb_cw(m_phase)) begin
        if (ena && m_pos < (1 << N) - 1) begin
          m_pos++;
          m_dir = 1;
          e.pos = m_pos; e.step = 1; e.dir = 1; e.err = 0;
          q.push_back(e);
        end
      end else if (p == tb_ccw(m_phase)) begin
        if (ena && m_pos > 0) begin
          m_pos--;
          m_dir = 0;
          e.pos = m_pos; e.step = 1; e.dir = 0; e.err = 0;
          q.push_back(e);
        end
      end else begin
        e.pos = m_pos; e.step = 0; e.dir = m_dir; e.err = 1;
        q.push_back(e);
      end
    end
    m_phase = p;
    repeat (hold - 1) @(posedge clk);
    if (hold >= 8) chk("drain", q.size(), 0);
  endtask

  task automatic rot_cw(input int n);
    for (int i = 0; i < n; i++) apply(tb_cw(m_phase), 10);
  endtask

  task automatic rot_ccw(input int n);
    for (int i = 0; i < n; i++) apply(tb_ccw(m_phase), 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int p0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", position, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("init_state", u_dut.r_state, Q_00);

    // CW through a full cycle of phases
    s0 = n_steps;
    rot_cw(4);
    chk("t1_pos", position, 4);
    chk("t1_steps", n_steps - s0, 4);
    chk("t1_dir", dir, 1);

    // CCW down to zero with saturation
    rot_ccw(2);
    chk("t2_start", position, 2);
    s0 = n_steps;
    rot_ccw(4);
    chk("t2_pos", position, 0);
    chk("t2_steps", n_steps - s0, 2);
    chk("t2_dir", dir, 0);

    // CW up to full scale with saturation
    rot_cw(13);
    chk("t3_start", position, 13);
    s0 = n_steps;
    rot_cw(4);
    chk("t3_pos", position, 15);
    chk("t3_steps", n_steps - s0, 2);

    while (m_phase != 2'b00) rot_cw(1);
    rot_ccw(4);

    // Short glitch on a_in is dropped; a glitch of exactly the window is accepted
    p0 = m_pos;
    s0 = n_steps;
    @(posedge clk);
    #1 a_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_in = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t4_filt", u_dut.w_filt, 2'b00);
    chk("t4_pos", position, p0);
    chk("t4_steps", n_steps - s0, 0);
    apply(2'b10, DC);
    chk("t4b_steps_pending", q.size(), 1);
    apply(2'b00, 10);
    chk("t4b_steps", n_steps - s0, 2);

    // Double-bit change flags err only
    p0 = m_pos;
    s0 = n_steps;
    apply(2'b11, 10);
    chk("t5_pos_after_err", position, p0);
    chk("t5_steps_err", n_steps - s0, 0);
    apply(2'b10, 10);
    chk("t5_pos", position, p0 + 1);

    // Disabled rotation tracks phase but does not count
    p0 = m_pos;
    s0 = n_steps;
    @(posedge clk);
    #1 ena = 1'b0;
    rot_cw(3);
    @(posedge clk);
    #1 ena = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_pos", position, p0);
    chk("t6_steps", n_steps - s0, 0);
    chk("t6_dir_before_rst", dir, 1);

    // Asynchronous reset in the middle of a debounce window
    @(posedge clk);
    #1 {a_in, b_in} = 2'b11;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_pos", position, 0);
    chk("t6_rst_step", step, 0);
    chk("t6_rst_dir", dir, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_state", u_dut.r_state, Q_INIT);
    q.delete();
    m_pos = 0;
    m_dir = 0;
    m_phase = 2'b11;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_load_state", u_dut.r_state, Q_11);
    chk("t6_load_pos", position, 0);
    chk("t6_load_q", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
